// File: rtl/mdu_iter.sv
// ============================================================================
// mdu_iter : multiply / multiply-accumulate / iterative restoring divide unit
//            owning the architectural HI/LO registers.
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module mdu_iter #(
   parameter int WIDTH   = 32,
   parameter int MUL_LAT = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             flush,
   input  logic [2:0]       mdop,
   input  logic [1:0]       wen,
   input  logic [WIDTH-1:0] op1,
   input  logic [WIDTH-1:0] op2,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   localparam int MAX_LAT = (MUL_LAT > WIDTH) ? MUL_LAT : WIDTH;
   localparam int CW      = $clog2(MAX_LAT + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2:0]         op_q, op_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   dvd_q, dvd_d;
   logic [WIDTH-1:0]   dvs_q, dvs_d;
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               done_q, done_d;

   logic               is_signed;
   logic [2*WIDTH-1:0] mul_a, mul_b, prod, hilo, mul_res;
   logic [WIDTH:0]     trial, diff;
   logic               qbit;
   logic [WIDTH-1:0]   rem_nx, dvd_nx, quo_fix, rem_fix;
   logic               start_signed_div;

   // Operand extension to 2*WIDTH makes a single unsigned multiplier exact
   // modulo 2^(2*WIDTH) for both signed and unsigned products.
   always_comb begin
      is_signed = ~op_q[0];
      mul_a     = {{WIDTH{is_signed & a_q[WIDTH-1]}}, a_q};
      mul_b     = {{WIDTH{is_signed & b_q[WIDTH-1]}}, b_q};
      prod      = mul_a * mul_b;
      hilo      = {hi_q, lo_q};
      case (op_q[2:1])
         2'b10:   mul_res = hilo + prod;
         2'b11:   mul_res = hilo - prod;
         default: mul_res = prod;
      endcase
   end

   // One restoring step: shift the next dividend bit into the partial
   // remainder and subtract the divisor when it fits.
   always_comb begin
      trial   = {rem_q, dvd_q[WIDTH-1]};
      diff    = trial - {1'b0, dvs_q};
      qbit    = ~diff[WIDTH];
      rem_nx  = qbit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
      dvd_nx  = {dvd_q[WIDTH-2:0], qbit};
      quo_fix = (is_signed && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -dvd_nx : dvd_nx;
      rem_fix = (is_signed && a_q[WIDTH-1]) ? -rem_nx : rem_nx;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      rem_d   = rem_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      start_signed_div = (mdop == 3'b010);

      if (flush) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end else if (state_q == S_IDLE && start) begin
         op_d  = mdop;
         a_d   = op1;
         b_d   = op2;
         rem_d = '0;
         dvd_d = (start_signed_div && op1[WIDTH-1]) ? -op1 : op1;
         dvs_d = (start_signed_div && op2[WIDTH-1]) ? -op2 : op2;
         if (mdop[2:1] == 2'b01) begin
            state_d = S_DIV;
            cnt_d   = CW'(WIDTH);
         end else begin
            state_d = S_MUL;
            cnt_d   = CW'(MUL_LAT);
         end
      end else if (state_q != S_IDLE) begin
         cnt_d = cnt_q - CW'(1);
         if (state_q == S_DIV) begin
            dvd_d = dvd_nx;
            rem_d = rem_nx;
         end
         if (cnt_q == CW'(1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            if (state_q == S_MUL) begin
               {hi_d, lo_d} = mul_res;
            end else if (b_q == '0) begin
               hi_d = a_q;
               lo_d = '1;
            end else begin
               hi_d = rem_fix;
               lo_d = quo_fix;
            end
         end
      end else begin
         if (wen[0]) lo_d = op1;
         if (wen[1]) hi_d = op1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         rem_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         rem_q   <= rem_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

   assign busy = (state_q != S_IDLE);
   assign done = done_q;
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mdu_iter.sv
// ============================================================================
// tb_mdu_iter : scoreboard bench for mdu_iter with an arithmetic reference model.
// Rev 1.0     : initial release
// ============================================================================
`default_nettype none

module tb_mdu_iter;

   localparam int W  = 32;
   localparam int ML = 5;

   logic          clk = 1'b0;
   logic          rst, start, flush;
   logic [2:0]    mdop;
   logic [1:0]    wen;
   logic [W-1:0]  op1, op2;
   logic          busy, done;
   logic [W-1:0]  HI, LO;

   int            checks = 0;
   int            failures = 0;
   int            done_seen = 0;
   logic [63:0]   exp_q[$];
   logic [31:0]   m_hi = '0;
   logic [31:0]   m_lo = '0;

   mdu_iter #(.WIDTH(W), .MUL_LAT(ML)) dut (
      .clk(clk), .rst(rst), .start(start), .flush(flush), .mdop(mdop),
      .wen(wen), .op1(op1), .op2(op2), .busy(busy), .done(done),
      .HI(HI), .LO(LO)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference: plain arithmetic on architectural values.
   function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] hi,
                                         input logic [31:0] lo);
      logic [63:0] p;
      longint      sa, sb;
      if (op[2:1] == 2'b01) begin
         if (b == 32'h0) return {a, 32'hFFFF_FFFF};
         if (op[0] == 1'b0) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return {32'(sa % sb), 32'(sa / sb)};
         end
         return {a % b, a / b};
      end
      if (op[0] == 1'b0) p = 64'(longint'($signed(a)) * longint'($signed(b)));
      else               p = {32'h0, a} * {32'h0, b};
      if (op[2:1] == 2'b10) return {hi, lo} + p;
      if (op[2:1] == 2'b11) return {hi, lo} - p;
      return p;
   endfunction

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (done) begin
         done_seen++;
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done actual=%h required=none", {HI, LO});
         end else begin
            chk("scoreboard_hilo", {HI, LO}, exp_q.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_wen(input logic [1:0] w, input logic [31:0] d);
      wen = w;
      op1 = d;
      tick();
      wen = 2'b00;
      if (w[0]) m_lo = d;
      if (w[1]) m_hi = d;
      chk("wen_hilo", {HI, LO}, {m_hi, m_lo});
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit inject, input bit wsame);
      logic [63:0] e;
      int          n, lat, d0;
      e   = model(op, a, b, m_hi, m_lo);
      exp_q.push_back(e);
      lat = (op[2:1] == 2'b01) ? W : ML;
      d0  = done_seen;
      mdop = op; op1 = a; op2 = b; start = 1'b1;
      if (wsame) wen = 2'b01;
      tick();
      start = 1'b0;
      wen   = 2'b00;
      if (wsame) chk("wen_ignored_with_start", {32'h0, LO}, {32'h0, m_lo});
      n = 0;
      while (busy && n < 100) begin
         if (inject && n == 1) begin
            start = 1'b1;
            mdop  = ~op;
            op1   = $urandom;
            op2   = $urandom;
         end else begin
            start = 1'b0;
         end
         tick();
         n++;
      end
      start = 1'b0;
      chk("busy_cycles", 64'(n), 64'(lat));
      @(negedge clk);
      #1;
      chk("done_pulses", 64'(done_seen - d0), 64'd1);
      chk("hilo_after_op", {HI, LO}, e);
      {m_hi, m_lo} = e;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      logic [2:0]  op;
      logic [31:0] a, b;
      rst = 1'b1; start = 1'b0; flush = 1'b0; mdop = '0; wen = '0; op1 = '0; op2 = '0;
      tick(); tick();
      rst = 1'b0;
      chk("reset_hilo", {HI, LO}, 64'h0);
      chk("reset_busy_done", {62'h0, busy, done}, 64'h0);

      issue(3'b000, 32'hFFFF_FFFF, 32'h0000_0002, 0, 0);
      issue(3'b001, 32'hFFFF_FFFF, 32'h0000_0002, 0, 0);
      issue(3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 0, 0);
      issue(3'b011, 32'd100, 32'd7, 0, 0);
      issue(3'b011, 32'h0000_1234, 32'h0, 0, 0);
      issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
      do_wen(2'b11, 32'h0000_000A);
      issue(3'b100, 32'd3, 32'd4, 0, 0);
      issue(3'b110, 32'h0000_0016, 32'd1, 0, 0);
      issue(3'b000, 32'h1234_5678, 32'h9ABC_DEF0, 1, 0);
      issue(3'b011, 32'd7, 32'd3, 1, 0);
      issue(3'b001, 32'd7, 32'd3, 0, 1);

      // Flush during divide leaves HI/LO untouched and produces no done.
      do_wen(2'b11, 32'd5);
      d0 = done_seen;
      mdop = 3'b010; op1 = 32'd100; op2 = 32'd3; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_busy", {63'h0, busy}, 64'h0);
      chk("flush_hilo", {HI, LO}, {32'd5, 32'd5});
      tick(); tick();
      chk("flush_no_done", 64'(done_seen - d0), 64'h0);
      issue(3'b011, 32'd9, 32'd3, 0, 0);

      // Idle flush suppresses both start and wen in that cycle.
      flush = 1'b1; start = 1'b1; mdop = 3'b000; wen = 2'b11; op1 = 32'hDEAD_BEEF;
      tick();
      flush = 1'b0; start = 1'b0; wen = 2'b00;
      chk("idle_flush_start", {63'h0, busy}, 64'h0);
      chk("idle_flush_wen", {HI, LO}, {m_hi, m_lo});

      // Synchronous reset on the 10th busy cycle discards the divide.
      mdop = 3'b010; op1 = 32'd1000; op2 = 32'd7; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (9) tick();
      rst = 1'b1;
      tick();
      chk("midop_reset_hilo", {HI, LO}, 64'h0);
      chk("midop_reset_busy_done", {62'h0, busy, done}, 64'h0);
      rst = 1'b0;
      m_hi = '0; m_lo = '0;

      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 9) == 0) begin
            do_wen(2'($urandom_range(1, 3)), $urandom);
         end else begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
               0: b = 32'h0;
               1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
               2: begin a = $urandom_range(0, 255); b = $urandom_range(1, 15); end
               default: ;
            endcase
            issue(op, a, b, 0, 0);
         end
      end

      chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
